// File: rtl/shared_reg_pkg.sv
// Shared types and widths for the shared register arbiter.
// Optional owner lock is enabled with the ARB_LOCK_EN macro.
package shared_reg_pkg;

    localparam int PTR_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit
// scanning from rr upward with wrap-around modulo N.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    always_comb begin
        int  idx;
        logic sel;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        sel     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr) + i;
            if (idx >= N) idx = idx - N;
            sel = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j == idx) sel = req[j];
            end
            if (!any_req && sel) begin
                any_req = 1'b1;
                winner  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit flop row between N requesters.
// Define ARB_LOCK_EN to let an owner keep the grant up to MAX_HOLD cycles.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [N*W-1:0]   data_in,
    input  logic [W-1:0]     reg_z,
    output logic [W-1:0]     reg_p,
    output logic [N-1:0]     grant,
    output logic [2:0]       owner,
    output logic             busy
);

    state_t           state, state_nx;
    logic [N-1:0]     grant_nx;
    logic [PTR_W-1:0] owner_nx;
    logic [PTR_W-1:0] rr, rr_nx;
    logic [PTR_W-1:0] winner;
    logic             any_req;
    logic             keep;
    logic [W-1:0]     owner_data;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .rr      (rr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        owner_data = '0;
        for (int j = 0; j < N; j++) begin
            if (PTR_W'(j) == owner) owner_data = data_in[j*W +: W];
        end
    end

`ifdef ARB_LOCK_EN
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              owner_req;
    logic              owner_lock;

    always_comb begin
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (PTR_W'(j) == owner) begin
                owner_req  = req[j];
                owner_lock = lock[j];
            end
        end
    end

    assign keep = (state == ST_GRANT) && owner_req && owner_lock
                  && (hold < HOLD_W'(MAX_HOLD));
`else
    logic unused_lock;
    assign unused_lock = ^{lock, MAX_HOLD[3:0]};
    assign keep        = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        owner_nx = owner;
        rr_nx    = rr;
`ifdef ARB_LOCK_EN
        hold_nx  = hold;
`endif
        if (keep) begin
`ifdef ARB_LOCK_EN
            hold_nx = hold + HOLD_W'(1);
`endif
        end else if (any_req) begin
            state_nx = ST_GRANT;
            owner_nx = winner;
            grant_nx = {{(N-1){1'b0}}, 1'b1} << winner;
            rr_nx    = (winner == PTR_W'(N-1)) ? '0 : winner + PTR_W'(1);
`ifdef ARB_LOCK_EN
            hold_nx  = HOLD_W'(1);
`endif
        end else begin
            state_nx = ST_IDLE;
            grant_nx = '0;
            owner_nx = '0;
`ifdef ARB_LOCK_EN
            hold_nx  = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= '0;
            rr    <= '0;
`ifdef ARB_LOCK_EN
            hold  <= '0;
`endif
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            owner <= owner_nx;
            rr    <= rr_nx;
`ifdef ARB_LOCK_EN
            hold  <= hold_nx;
`endif
        end
    end

    assign busy = |grant;

    // Reset forces zero into the flop row so it clears with the arbiter.
    always_comb begin
        if (!resetn)   reg_p = '0;
        else if (busy) reg_p = owner_data;
        else           reg_p = reg_z;
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter with a plain D flop row model.
// Lock expectations follow the ARB_LOCK_EN macro.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] data_in;
    logic [W-1:0]   reg_z;
    logic [W-1:0]   reg_p;
    logic [N-1:0]   grant;
    logic [2:0]     owner;
    logic           busy;

    int n_chk;
    int n_fail;

    logic [W-1:0] sl [N];

    shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .req     (req),
        .lock    (lock),
        .data_in (data_in),
        .reg_z   (reg_z),
        .reg_p   (reg_p),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The register row: plain D flops, no enable, no reset.
    always_ff @(posedge clock) reg_z <= reg_p;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [N-1:0] lk_seq [5];
        n_chk  = 0;
        n_fail = 0;
        sl[0] = 8'h11;
        sl[1] = 8'h22;
        sl[2] = 8'hA5;
        sl[3] = 8'h44;
        data_in = {sl[3], sl[2], sl[1], sl[0]};
        resetn = 1'b0;
        req    = 4'b1111;
        lock   = 4'b0000;
        #1;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_reg_p", 32'(reg_p), 32'h0);
        chk("rst_reg_z", 32'(reg_z), 32'h0);

        // single request to index 2
        resetn = 1'b1;
        req    = 4'b0100;
        step();
        chk("one_grant", 32'(grant), 32'h4);
        chk("one_owner", 32'(owner), 32'h2);
        chk("one_busy",  32'(busy),  32'h1);
        chk("one_reg_p", 32'(reg_p), 32'hA5);
        req = 4'b0000;
        step();
        chk("one_reg_z", 32'(reg_z), 32'hA5);
        chk("one_idle",  32'(grant), 32'h0);
        chk("one_ibusy", 32'(busy),  32'h0);
        chk("one_hold",  32'(reg_p), 32'hA5);
        step();
        chk("one_keep",  32'(reg_z), 32'hA5);

        // fairness from reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        req    = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            chk("rr_reg_p", 32'(reg_p), 32'(sl[i % 4]));
        end
        chk("rr_reg_z", 32'(reg_z), 32'(sl[2]));

        // wrap-around after grant to index 3
        req = 4'b1001;
        step();
        chk("wrap_grant", 32'(grant), 32'h1);
        chk("wrap_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        step();
        chk("wrap_idle", 32'(grant), 32'h0);
        chk("wrap_reg_z", 32'(reg_z), 32'(sl[0]));

        // lock on requester 0
`ifdef ARB_LOCK_EN
        lk_seq[0] = 4'b0001;
        lk_seq[1] = 4'b0001;
        lk_seq[2] = 4'b0001;
        lk_seq[3] = 4'b0001;
        lk_seq[4] = 4'b0010;
`else
        lk_seq[0] = 4'b0001;
        lk_seq[1] = 4'b0010;
        lk_seq[2] = 4'b0001;
        lk_seq[3] = 4'b0010;
        lk_seq[4] = 4'b0001;
`endif
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        req    = 4'b0011;
        lock   = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_grant", 32'(grant), 32'(lk_seq[i]));
        end
        lock = 4'b0000;
        req  = 4'b0000;
        step();
        chk("lock_idle", 32'(busy), 32'h0);

        // reset in the middle of a grant
        req = 4'b0010;
        step();
        chk("mid_grant", 32'(grant), 32'h2);
        resetn = 1'b0;
        #1;
        chk("mid_reg_p", 32'(reg_p), 32'h0);
        step();
        chk("mid_rgrant", 32'(grant), 32'h0);
        chk("mid_rowner", 32'(owner), 32'h0);
        chk("mid_reg_z",  32'(reg_z), 32'h0);
        resetn = 1'b1;
        req    = 4'b0010;
        step();
        chk("mid_again", 32'(grant), 32'h2);
        chk("mid_own",   32'(owner), 32'h1);
        req = 4'b0000;
        step();
        chk("mid_wr",    32'(reg_z), 32'(sl[1]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
